// File: rtl/shoe_shuffler_if.sv
// ---------------------------------------------------------------------------
// shoe_shuffler_if
//   Bundles the control and dealing signals between the blackjack controller
//   (master side) and the shoe shuffler (slave side).
//
//   Parameter: NUM_DECKS sets the width of the remaining-card count.
//
//   Master drives : shuffle_req, seed_load, seed, card_ready
//   Slave drives  : card_valid, card, busy, shuffle_done, remaining,
//                   low_water, empty
// ---------------------------------------------------------------------------
interface shoe_shuffler_if #(
  parameter int NUM_DECKS = 1
);
  localparam int N     = 52 * NUM_DECKS;
  localparam int CNT_W = $clog2(N + 1);

  logic             shuffle_req;
  logic             seed_load;
  logic [15:0]      seed;
  logic             card_ready;
  logic             card_valid;
  logic [5:0]       card;
  logic             busy;
  logic             shuffle_done;
  logic [CNT_W-1:0] remaining;
  logic             low_water;
  logic             empty;

  modport master (
    output shuffle_req, seed_load, seed, card_ready,
    input  card_valid, card, busy, shuffle_done, remaining, low_water, empty
  );

  modport slave (
    input  shuffle_req, seed_load, seed, card_ready,
    output card_valid, card, busy, shuffle_done, remaining, low_water, empty
  );
endinterface

// File: rtl/shoe_shuffler.sv
// ---------------------------------------------------------------------------
// shoe_shuffler
//   Multi-deck shoe generator. On request it fills a shoe of NUM_DECKS*52 card
//   codes, permutes it in place with a Fisher-Yates shuffle whose random index
//   comes from a 16-bit Galois LFSR (rejection sampling, so no modulo bias),
//   then deals the cards one at a time, top of shoe = shoe[remaining-1].
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   bus (slave)    shuffle_req / seed_load / seed / card_ready in,
//                  card_valid / card / busy / shuffle_done / remaining /
//                  low_water / empty out (all outputs registered)
//
// Parameters
//   NUM_DECKS  decks in the shoe (1..8)
//   CUT_LEVEL  low_water asserts in DEAL once remaining <= CUT_LEVEL
//   SEED       LFSR value after reset; also substituted for a loaded seed of 0
// ---------------------------------------------------------------------------
module shoe_shuffler #(
  parameter int          NUM_DECKS = 1,
  parameter int          CUT_LEVEL = 15,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  shoe_shuffler_if.slave bus
);

  localparam int N     = 52 * NUM_DECKS;
  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = $clog2(N);

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_CUT  = CNT_W'(CUT_LEVEL);
  localparam logic [5:0]       CODE_LAST = 6'd51;
  // Toggle mask for x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
  localparam logic [15:0]      LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    PICK = 3'd2,
    SWAP = 3'd3,
    DEAL = 3'd4
  } state_e;

  // One Galois LFSR step
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Smallest 2^k-1 covering i: smear the top set bit of i downwards
  function automatic logic [IDX_W-1:0] idx_mask(input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] m;
    m = i;
    for (int k = 0; k < IDX_W; k++) begin
      m = m | (m >> 1'b1);
    end
    idx_mask = m;
  endfunction

  // A zero seed would lock the LFSR, so it is replaced with the reset seed
  function automatic logic [15:0] seed_value(input logic [15:0] s);
    seed_value = (s == 16'h0000) ? SEED : s;
  endfunction

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [IDX_W-1:0] idx_q, idx_d;         // fill index in INIT, Fisher-Yates i in PICK/SWAP
  logic [5:0]       code_q, code_d;       // idx mod 52 tracked incrementally during INIT
  logic [IDX_W-1:0] j_q, j_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [5:0]       card_q, card_d;
  logic             card_valid_q, card_valid_d;
  logic             shuffle_done_q, shuffle_done_d;
  logic             busy_q, busy_d;
  logic             low_water_q, low_water_d;
  logic             empty_q, empty_d;

  logic [5:0]       shoe_q [0:N-1];

  logic             wr_a_en_s;
  logic [IDX_W-1:0] wr_a_addr_s;
  logic [5:0]       wr_a_data_s;
  logic             wr_b_en_s;
  logic [IDX_W-1:0] wr_b_addr_s;
  logic [5:0]       wr_b_data_s;
  logic [IDX_W-1:0] pick_j_s;
  logic [IDX_W-1:0] rd_addr_s;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_q;
    idx_d          = idx_q;
    code_d         = code_q;
    j_d            = j_q;
    remaining_d    = remaining_q;
    card_d         = card_q;
    card_valid_d   = card_valid_q;
    shuffle_done_d = 1'b0;

    wr_a_en_s   = 1'b0;
    wr_a_addr_s = idx_q;
    wr_a_data_s = code_q;
    wr_b_en_s   = 1'b0;
    wr_b_addr_s = j_q;
    wr_b_data_s = shoe_q[idx_q];

    pick_j_s  = lfsr_q[IDX_W-1:0] & idx_mask(idx_q);
    rd_addr_s = IDX_W'(remaining_q - CNT_ONE);

    case (state_q)
      IDLE: begin
        if (bus.seed_load) begin
          lfsr_d = seed_value(bus.seed);
        end else begin
          lfsr_d = lfsr_q;
        end
        if (bus.shuffle_req) begin
          state_d      = INIT;
          idx_d        = IDX_ZERO;
          code_d       = 6'd0;
          remaining_d  = CNT_ZERO;
          card_valid_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      INIT: begin
        wr_a_en_s = 1'b1;
        if (idx_q == IDX_LAST) begin
          // idx already holds N-1, the first Fisher-Yates position
          state_d = PICK;
        end else begin
          idx_d  = idx_q + IDX_ONE;
          code_d = (code_q == CODE_LAST) ? 6'd0 : code_q + 6'd1;
        end
      end

      PICK: begin
        lfsr_d = lfsr_step(lfsr_q);
        if (pick_j_s <= idx_q) begin
          j_d     = pick_j_s;
          state_d = SWAP;
        end else begin
          // Out-of-range draw is rejected and retried with the next LFSR value
          state_d = PICK;
        end
      end

      SWAP: begin
        // Port B writes last, so j == i simply rewrites the same value
        wr_a_en_s   = 1'b1;
        wr_a_addr_s = idx_q;
        wr_a_data_s = shoe_q[j_q];
        wr_b_en_s   = 1'b1;
        wr_b_addr_s = j_q;
        wr_b_data_s = shoe_q[idx_q];
        if (idx_q == IDX_ONE) begin
          state_d        = DEAL;
          remaining_d    = CNT_FULL;
          shuffle_done_d = 1'b1;
        end else begin
          idx_d   = idx_q - IDX_ONE;
          state_d = PICK;
        end
      end

      DEAL: begin
        if (bus.seed_load) begin
          lfsr_d = seed_value(bus.seed);
        end else begin
          lfsr_d = lfsr_q;
        end
        if (bus.shuffle_req) begin
          // Reshuffle abandons whatever is left in the shoe
          state_d      = INIT;
          idx_d        = IDX_ZERO;
          code_d       = 6'd0;
          remaining_d  = CNT_ZERO;
          card_valid_d = 1'b0;
        end else if (card_valid_q) begin
          if (bus.card_ready) begin
            remaining_d  = remaining_q - CNT_ONE;
            card_valid_d = 1'b0;
          end else begin
            card_valid_d = 1'b1;
          end
        end else if (remaining_q != CNT_ZERO) begin
          // Card is captured only while not valid, so it holds through a stall
          card_d       = shoe_q[rd_addr_s];
          card_valid_d = 1'b1;
        end else begin
          card_valid_d = 1'b0;
        end
      end

      default: begin
        state_d      = IDLE;
        card_valid_d = 1'b0;
      end
    endcase

    busy_d      = (state_d == INIT) || (state_d == PICK) || (state_d == SWAP);
    low_water_d = (state_d == DEAL) && (remaining_d <= CNT_CUT);
    empty_d     = (state_d == DEAL) && (remaining_d == CNT_ZERO);
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      lfsr_q         <= SEED;
      idx_q          <= IDX_ZERO;
      code_q         <= 6'd0;
      j_q            <= IDX_ZERO;
      remaining_q    <= CNT_ZERO;
      card_q         <= 6'd0;
      card_valid_q   <= 1'b0;
      shuffle_done_q <= 1'b0;
      busy_q         <= 1'b0;
      low_water_q    <= 1'b0;
      empty_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      idx_q          <= idx_d;
      code_q         <= code_d;
      j_q            <= j_d;
      remaining_q    <= remaining_d;
      card_q         <= card_d;
      card_valid_q   <= card_valid_d;
      shuffle_done_q <= shuffle_done_d;
      busy_q         <= busy_d;
      low_water_q    <= low_water_d;
      empty_q        <= empty_d;
    end
  end

  // Shoe storage: two write ports, no reset since INIT rebuilds every entry
  always_ff @(posedge clk) begin
    if (wr_a_en_s) begin
      shoe_q[wr_a_addr_s] <= wr_a_data_s;
    end
    if (wr_b_en_s) begin
      shoe_q[wr_b_addr_s] <= wr_b_data_s;
    end
  end

  assign bus.card_valid   = card_valid_q;
  assign bus.card         = card_q;
  assign bus.busy         = busy_q;
  assign bus.shuffle_done = shuffle_done_q;
  assign bus.remaining    = remaining_q;
  assign bus.low_water    = low_water_q;
  assign bus.empty        = empty_q;

endmodule

// File: tb/tb_shoe_shuffler.sv
// ---------------------------------------------------------------------------
// tb_shoe_shuffler
//   Drives a one-deck and a two-deck shuffler. Expected deal order comes from
//   a plain Fisher-Yates model over an int array using the same LFSR sequence;
//   permutation properties are checked by counting codes.
// ---------------------------------------------------------------------------
module tb_shoe_shuffler;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shoe_shuffler_if #(.NUM_DECKS(1)) if1 ();
  shoe_shuffler_if #(.NUM_DECKS(2)) if2 ();

  shoe_shuffler #(.NUM_DECKS(1), .CUT_LEVEL(15), .SEED(16'hACE1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );
  shoe_shuffler #(.NUM_DECKS(2), .CUT_LEVEL(15), .SEED(16'hACE1)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave)
  );

  int          n_checks;
  int          n_errors;
  int          mdeck [0:415];
  logic [15:0] m_lfsr1;
  logic [15:0] m_lfsr2;
  int          m_rem1;
  int          dealt [$];
  int          seq_a [$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Reference shuffle: fill k%52, then i = n-1 downto 1, rejection-sampled j
  task automatic model_shuffle(input int n, inout logic [15:0] lf);
    int j, m, t;
    for (int k = 0; k < n; k++) mdeck[k] = k % 52;
    for (int i = n - 1; i >= 1; i--) begin
      m = 1;
      while (m < i) m = m * 2 + 1;
      j = int'(lf) & m;
      lf = lfsr_next(lf);
      while (j > i) begin
        j = int'(lf) & m;
        lf = lfsr_next(lf);
      end
      t = mdeck[i]; mdeck[i] = mdeck[j]; mdeck[j] = t;
    end
  endtask

  task automatic check_counts(input int copies);
    int cnt [0:51];
    int bad;
    bad = 0;
    for (int c = 0; c < 52; c++) cnt[c] = 0;
    foreach (dealt[q]) begin
      if (dealt[q] >= 0 && dealt[q] < 52) cnt[dealt[q]]++;
      else bad++;
    end
    for (int c = 0; c < 52; c++) if (cnt[c] != copies) bad++;
    check_eq("perm_len", dealt.size(), 52 * copies);
    check_eq("perm_codes_bad", bad, 0);
  endtask

  task automatic check_reset1();
    check_eq("rst_valid", int'(if1.card_valid), 0);
    check_eq("rst_card", int'(if1.card), 0);
    check_eq("rst_busy", int'(if1.busy), 0);
    check_eq("rst_done", int'(if1.shuffle_done), 0);
    check_eq("rst_rem", int'(if1.remaining), 0);
    check_eq("rst_low", int'(if1.low_water), 0);
    check_eq("rst_empty", int'(if1.empty), 0);
  endtask

  task automatic start1(input bit ld, input logic [15:0] sd);
    if1.seed_load   = ld;
    if1.seed        = sd;
    if1.shuffle_req = 1'b1;
    tick();
    if1.shuffle_req = 1'b0;
    if1.seed_load   = 1'b0;
    if (ld) m_lfsr1 = (sd == 16'h0000) ? 16'hACE1 : sd;
    model_shuffle(52, m_lfsr1);
    m_rem1 = 0;
    dealt.delete();
    check_eq("start_busy", int'(if1.busy), 1);
    check_eq("start_valid", int'(if1.card_valid), 0);
    check_eq("start_rem", int'(if1.remaining), 0);
  endtask

  task automatic wait_done1();
    int cyc;
    cyc = 0;
    while (!if1.shuffle_done && cyc < 5000) begin
      tick();
      cyc++;
    end
    check_eq("done_seen", int'(if1.shuffle_done), 1);
    check_eq("done_rem", int'(if1.remaining), 52);
    check_eq("done_busy", int'(if1.busy), 0);
    check_eq("done_low", int'(if1.low_water), 0);
    m_rem1 = 52;
    tick();
    check_eq("done_pulse", int'(if1.shuffle_done), 0);
  endtask

  task automatic wait_valid1();
    int cyc;
    cyc = 0;
    while (!if1.card_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq("valid_seen", int'(if1.card_valid), 1);
  endtask

  task automatic deal1(input int count, input bit rand_ready);
    int got, budget;
    got = 0;
    budget = 0;
    while (got < count && budget < count * 40 + 40) begin
      if1.card_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      check_eq("deal_rem", int'(if1.remaining), m_rem1);
      check_eq("deal_low", int'(if1.low_water), (m_rem1 <= 15) ? 1 : 0);
      if (if1.card_valid) begin
        if (m_rem1 > 0) begin
          check_eq("deal_card", int'(if1.card), mdeck[m_rem1 - 1]);
          if (if1.card_ready) begin
            dealt.push_back(int'(if1.card));
            m_rem1--;
            got++;
          end
        end else begin
          check_eq("deal_valid_when_empty", int'(if1.card_valid), 0);
        end
      end
      tick();
      budget++;
    end
    if1.card_ready = 1'b0;
    check_eq("deal_count", got, count);
  endtask

  initial begin
    int cyc, rem2, first_low, diffs, c0, r0;
    logic [15:0] rs;

    n_checks = 0;
    n_errors = 0;
    if1.shuffle_req = 1'b0; if1.seed_load = 1'b0; if1.seed = 16'h0000; if1.card_ready = 1'b0;
    if2.shuffle_req = 1'b0; if2.seed_load = 1'b0; if2.seed = 16'h0000; if2.card_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset1();
    rst = 1'b0;
    m_lfsr1 = 16'hACE1;
    m_lfsr2 = 16'hACE1;
    tick();

    // T2: two decks, every code twice, low_water first at 15
    if2.shuffle_req = 1'b1;
    tick();
    if2.shuffle_req = 1'b0;
    model_shuffle(104, m_lfsr2);
    check_eq("t2_busy", int'(if2.busy), 1);
    cyc = 0;
    while (!if2.shuffle_done && cyc < 5000) begin
      tick();
      cyc++;
    end
    check_eq("t2_done", int'(if2.shuffle_done), 1);
    check_eq("t2_rem_full", int'(if2.remaining), 104);
    rem2 = 104;
    first_low = -1;
    dealt.delete();
    if2.card_ready = 1'b1;
    cyc = 0;
    while (rem2 > 0 && cyc < 2000) begin
      if (if2.low_water && first_low < 0) first_low = int'(if2.remaining);
      if (if2.card_valid) begin
        check_eq("t2_card", int'(if2.card), mdeck[rem2 - 1]);
        check_eq("t2_rem", int'(if2.remaining), rem2);
        dealt.push_back(int'(if2.card));
        rem2--;
      end
      tick();
      cyc++;
    end
    if2.card_ready = 1'b0;
    check_eq("t2_all_dealt", rem2, 0);
    check_eq("t2_first_low", first_low, 15);
    check_eq("t2_empty", int'(if2.empty), 1);
    check_counts(2);

    // T1: one deck, full deal then empty
    start1(1'b0, 16'h0000);
    wait_done1();
    deal1(52, 1'b0);
    check_counts(1);
    check_eq("t1_empty", int'(if1.empty), 1);
    check_eq("t1_low_at_zero", int'(if1.low_water), 1);
    repeat (3) tick();
    check_eq("t1_valid_after_empty", int'(if1.card_valid), 0);
    check_eq("t1_rem_zero", int'(if1.remaining), 0);

    // T3: same seed twice gives same order; seed 0 behaves as SEED
    start1(1'b1, 16'h1234);
    wait_done1();
    deal1(52, 1'b1);
    seq_a = dealt;
    start1(1'b1, 16'h1234);
    wait_done1();
    deal1(52, 1'b0);
    diffs = 0;
    foreach (dealt[q]) if (dealt[q] != seq_a[q]) diffs++;
    check_eq("t3_repeat_diff", diffs, 0);
    start1(1'b1, 16'h0000);
    wait_done1();
    deal1(52, 1'b1);
    seq_a = dealt;
    start1(1'b1, 16'hACE1);
    wait_done1();
    deal1(52, 1'b0);
    diffs = 0;
    foreach (dealt[q]) if (dealt[q] != seq_a[q]) diffs++;
    check_eq("t3_zero_seed_diff", diffs, 0);
    for (int r = 0; r < 2; r++) begin
      rs = 16'($urandom_range(1, 65535));
      start1(1'b1, rs);
      wait_done1();
      deal1(52, 1'b1);
      check_counts(1);
    end

    // T4: dealer stall holds the presented card
    start1(1'b0, 16'h0000);
    wait_done1();
    deal1(5, 1'b0);
    wait_valid1();
    c0 = int'(if1.card);
    r0 = int'(if1.remaining);
    check_eq("t4_card_model", c0, mdeck[m_rem1 - 1]);
    for (int s = 0; s < 10; s++) begin
      tick();
      check_eq("t4_valid_hold", int'(if1.card_valid), 1);
      check_eq("t4_card_hold", int'(if1.card), c0);
      check_eq("t4_rem_hold", int'(if1.remaining), r0);
    end
    deal1(47, 1'b1);
    check_counts(1);

    // T5: reshuffle mid-deal; requests and seed loads during busy are ignored
    start1(1'b0, 16'h0000);
    wait_done1();
    deal1(22, 1'b0);
    check_eq("t5_rem30", int'(if1.remaining), 30);
    wait_valid1();
    start1(1'b0, 16'h0000);
    repeat (60) tick();
    check_eq("t5_busy_mid", int'(if1.busy), 1);
    if1.shuffle_req = 1'b1;
    if1.seed_load   = 1'b1;
    if1.seed        = 16'h5555;
    tick();
    if1.shuffle_req = 1'b0;
    if1.seed_load   = 1'b0;
    wait_done1();
    deal1(52, 1'b1);
    check_counts(1);

    // T6: async reset in the middle of the shuffle
    start1(1'b0, 16'h0000);
    repeat (70) tick();
    check_eq("t6_busy_before", int'(if1.busy), 1);
    rst = 1'b1;
    #1;
    check_reset1();
    tick();
    rst = 1'b0;
    m_lfsr1 = 16'hACE1;
    tick();
    start1(1'b0, 16'h0000);
    wait_done1();
    deal1(52, 1'b1);
    check_counts(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
